// File: rtl/iqmod_pkg.sv
// Shared constants and saturation helper for the IQ modulator/demodulator paths.
package iqmod_pkg;
  localparam int ADC_W   = 10;
  localparam int IQ_W    = 8;
  localparam int ADC_MID = 512;

  function automatic logic signed [IQ_W-1:0] sat8(input logic signed [31:0] v);
    if (v > 32'sd127)
      return 8'sd127;
    else if (v < -32'sd128)
      return -8'sd128;
    else
      return v[IQ_W-1:0];
  endfunction
endpackage

// File: rtl/iq_demod_if.sv
// Sample-in / IQ-out bundle between the ADC capture register and symbol logic.
interface iq_demod_if;
  import iqmod_pkg::*;

  logic [ADC_W-1:0]       adcval;
  logic                   adcvalid;
  logic                   phsync;
  logic signed [IQ_W-1:0] i;
  logic signed [IQ_W-1:0] q;
  logic                   iqvalid;

  modport master (output adcval, adcvalid, phsync, input i, q, iqvalid);
  modport slave  (input adcval, adcvalid, phsync, output i, q, iqvalid);
endinterface

// File: rtl/iq_dump.sv
// One integrate-and-dump channel: accumulate, scale, saturate, register.
// IQDEMOD_ROUND_EN selects round-half-up scaling instead of floor.
module iq_dump
  import iqmod_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic                   i_dump,
  input  logic signed [11:0]     i_mix,
  output logic signed [IQ_W-1:0] o_val
);
  localparam int ACC_W = ADC_W + LOG2N;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [IQ_W-1:0]  r_val;
  logic signed [ACC_W-1:0] w_mix;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_pre;
  logic signed [ACC_W-1:0] w_shift;

  assign w_mix = ACC_W'(i_mix);
  assign w_sum = r_acc + w_mix;
`ifdef IQDEMOD_ROUND_EN
  assign w_pre = w_sum + ACC_W'(1 << LOG2N);
`else
  assign w_pre = w_sum;
`endif
  assign w_shift = w_pre >>> (LOG2N + 1);

  // A realign with a sample present seeds the new block with that sample.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_acc <= '0;
      r_val <= '0;
    end else if (i_clr) begin
      r_acc <= i_en ? w_mix : '0;
    end else if (i_en) begin
      if (i_dump) begin
        r_acc <= '0;
        r_val <= sat8(32'(w_shift));
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  assign o_val = r_val;
endmodule

// File: rtl/iq_demod.sv
// fs/4 quadrature demodulator with integrate-and-dump over 2^LOG2N samples.
// Rounding mode is selected inside iq_dump by IQDEMOD_ROUND_EN.
module iq_demod
  import iqmod_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input  logic  clk,
  input  logic  reset_,
  iq_demod_if.slave bus
);
  logic [LOG2N-1:0]  r_cnt;
  logic              r_iqvalid;
  logic              w_acc;
  logic              w_clr;
  logic              w_dump;
  logic [1:0]        w_ph;
  logic signed [11:0] w_s;
  logic signed [11:0] w_neg;
  logic signed [11:0] w_mi;
  logic signed [11:0] w_mq;

  assign w_acc  = bus.adcvalid;
  assign w_clr  = bus.phsync;
  assign w_dump = w_acc & ~w_clr & (&r_cnt);
  // N is a multiple of 4, so the LO phase is simply the low bits of the sample count.
  assign w_ph   = w_clr ? 2'd0 : r_cnt[1:0];
  assign w_s    = $signed({2'b00, bus.adcval}) - 12'(ADC_MID);
  assign w_neg  = -w_s;

  always_comb begin
    w_mi = '0;
    w_mq = '0;
    case (w_ph)
      2'd0:    w_mi = w_s;
      2'd1:    w_mq = w_neg;
      2'd2:    w_mi = w_neg;
      default: w_mq = w_s;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_cnt     <= '0;
      r_iqvalid <= 1'b0;
    end else begin
      r_iqvalid <= w_dump;
      if (w_clr)
        r_cnt <= {{(LOG2N-1){1'b0}}, w_acc};
      else if (w_acc)
        r_cnt <= r_cnt + LOG2N'(1);
    end
  end

  iq_dump #(.LOG2N(LOG2N)) u_dump_i (
    .clk    (clk),
    .reset_ (reset_),
    .i_en   (w_acc),
    .i_clr  (w_clr),
    .i_dump (w_dump),
    .i_mix  (w_mi),
    .o_val  (bus.i)
  );

  iq_dump #(.LOG2N(LOG2N)) u_dump_q (
    .clk    (clk),
    .reset_ (reset_),
    .i_en   (w_acc),
    .i_clr  (w_clr),
    .i_dump (w_dump),
    .i_mix  (w_mq),
    .o_val  (bus.q)
  );

  assign bus.iqvalid = r_iqvalid;
endmodule

// File: tb/tb_iq_demod.sv
// Self-checking bench for iq_demod against a block-sum reference model.
module tb_iq_demod;
  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  iq_demod_if bus ();

  iq_demod #(.LOG2N(LOG2N)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int blk[$];
  int m_i = 0;
  int m_q = 0;
  bit m_strobe = 1'b0;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int scale(input int sum);
    real r;
    int  f;
    r = real'(sum);
`ifdef IQDEMOD_ROUND_EN
    r = r + real'(N);
`endif
    f = int'($floor(r / real'(2 * N)));
    if (f > 127) f = 127;
    if (f < -128) f = -128;
    return f;
  endfunction

  // Reference: a block is the list of its signed samples; the k-th sample
  // is mixed with cos/-sin of k*pi/2 and the block sum is scaled.
  task automatic model_edge(input bit v, input int val, input bit sync);
    int si, sq;
    m_strobe = 1'b0;
    if (sync) blk.delete();
    if (v) begin
      blk.push_back(val - 512);
      if (blk.size() == N) begin
        si = 0;
        sq = 0;
        foreach (blk[k]) begin
          case (k % 4)
            0: si += blk[k];
            1: sq -= blk[k];
            2: si -= blk[k];
            default: sq += blk[k];
          endcase
        end
        m_i = scale(si);
        m_q = scale(sq);
        m_strobe = 1'b1;
        blk.delete();
      end
    end
  endtask

  task automatic cyc(input bit v, input int val, input bit sync);
    @(negedge clk);
    check("iqvalid", int'(bus.iqvalid), int'(m_strobe));
    check("i", int'($signed(bus.i)), m_i);
    check("q", int'($signed(bus.q)), m_q);
    bus.adcvalid = v;
    bus.adcval   = 10'(val);
    bus.phsync   = sync;
    model_edge(v, val, sync);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, int'($urandom_range(0, 1023)), 1'b0);
  endtask

  task automatic run_pat(input int a, input int b, input int c, input int d,
                         input int reps, input int gapmax);
    int pat[4];
    pat = '{a, b, c, d};
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
        cyc(1'b1, pat[k], 1'b0);
      end
    end
    idle(2);
  endtask

  initial begin
    bus.adcval   = 10'd512;
    bus.adcvalid = 1'b0;
    bus.phsync   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_i", int'($signed(bus.i)), 0);
    check("rst_q", int'($signed(bus.q)), 0);
    check("rst_iqvalid", int'(bus.iqvalid), 0);
    reset_ = 1'b1;

    run_pat(512, 512, 512, 512, 4, 0);
    run_pat(614, 512, 410, 512, 4, 0);
    run_pat(512, 412, 512, 612, 4, 0);
    run_pat(1023, 512, 1, 512, 4, 0);
    run_pat(1, 512, 1023, 512, 4, 0);
    run_pat(614, 512, 410, 512, 4, 3);
    run_pat(1, 1023, 1023, 1, 4, 2);

    // Partial block then bare realign, then a clean block.
    for (int k = 0; k < 7; k++) cyc(1'b1, 700, 1'b0);
    cyc(1'b0, 512, 1'b1);
    run_pat(614, 512, 410, 512, 4, 0);

    // Realign carrying a sample, and realign on what would be sample N-1.
    for (int k = 0; k < 5; k++) cyc(1'b1, 300, 1'b0);
    cyc(1'b1, 900, 1'b1);
    for (int k = 0; k < N - 2; k++) cyc(1'b1, 512 + 30 * (k % 3), 1'b0);
    cyc(1'b1, 1000, 1'b1);
    for (int k = 0; k < N - 1; k++) cyc(1'b1, 200 + k * 40, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of a block.
    run_pat(1023, 512, 1, 512, 4, 0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 800, 1'b0);
    @(negedge clk);
    bus.adcvalid = 1'b0;
    bus.phsync   = 1'b0;
    #1 reset_ = 1'b0;
    #1;
    check("async_rst_i", int'($signed(bus.i)), 0);
    check("async_rst_q", int'($signed(bus.q)), 0);
    check("async_rst_iqvalid", int'(bus.iqvalid), 0);
    blk.delete();
    m_i = 0;
    m_q = 0;
    m_strobe = 1'b0;
    @(posedge clk);
    #2 reset_ = 1'b1;
    run_pat(512, 612, 512, 412, 4, 0);

    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
          $urandom_range(0, 60) == 0);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
